// File: rtl/priority_enc_pkg.sv
// Shared FSM states, default request count and clog2 helper for the priority encoder family.
package priority_enc_pkg;

  localparam int DEFAULT_N_IN = 8;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_enc_n_v.sv
// Combinational N-input fixed-priority encoder; the highest set index wins.
module priority_enc_n_v #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_code,
  output logic         o_valid
);

  always_comb begin
    o_code  = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_code  = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_enc_q_v.sv
// Registered priority encoder funnel: sticky pending vector, one granted code per cycle on valid/ready.
// Build option PRIORITY_ENC_Q_RR_EN switches from fixed highest-index priority to round-robin.
module priority_enc_q_v
  import priority_enc_pkg::*;
#(
  parameter int  N_IN   = DEFAULT_N_IN,
  localparam int W_CODE = clog2(N_IN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_IN-1:0]   i_req,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_CODE-1:0] o_code,
  output logic [N_IN-1:0]   o_pend,
  output logic              o_any
);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     pend_q, pend_d;
  logic                valid_q, valid_d;
  logic [W_CODE-1:0]   code_q, code_d;
  logic                accept;
  logic [N_IN-1:0]     clr;
  logic [N_IN-1:0]     enc_in;
  logic [W_CODE-1:0]   enc_code;
  logic                enc_valid;

  assign accept = valid_q & i_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[code_q] = 1'b1;
    pend_d = (pend_q & ~clr) | i_req;
  end

  // IDLE grants from the registered vector; a completing handshake looks ahead at the next one
  assign enc_in = (state_q == ST_PRESENT) ? pend_d : pend_q;

`ifdef PRIORITY_ENC_Q_RR_EN
  logic [W_CODE-1:0] last_q, last_d;
  logic [N_IN-1:0]   rr_mask;
  logic [W_CODE-1:0] masked_code, full_code;
  logic              masked_valid;

  always_comb begin
    last_d  = accept ? code_q : last_q;
    rr_mask = '0;
    for (int i = 0; i < N_IN; i++) begin
      rr_mask[i] = (i < int'(last_d));
    end
  end

  priority_enc_n_v #(.N(N_IN), .W(W_CODE)) u_enc_masked (
    .i_vec   (enc_in & rr_mask),
    .o_code  (masked_code),
    .o_valid (masked_valid)
  );

  priority_enc_n_v #(.N(N_IN), .W(W_CODE)) u_enc_full (
    .i_vec   (enc_in),
    .o_code  (full_code),
    .o_valid (enc_valid)
  );

  assign enc_code = masked_valid ? masked_code : full_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= W_CODE'(N_IN - 1);
    else       last_q <= last_d;
  end
`else
  priority_enc_n_v #(.N(N_IN), .W(W_CODE)) u_enc (
    .i_vec   (enc_in),
    .o_code  (enc_code),
    .o_valid (enc_valid)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enc_valid) state_d = ST_PRESENT;
      ST_PRESENT: if (i_ready && !enc_valid) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A held (not yet accepted) code never gets preempted
  always_comb begin
    valid_d = 1'b0;
    code_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          valid_d = 1'b1;
          code_d  = enc_code;
        end
      end
      ST_PRESENT: begin
        if (!i_ready) begin
          valid_d = 1'b1;
          code_d  = code_q;
        end else if (enc_valid) begin
          valid_d = 1'b1;
          code_d  = enc_code;
        end
      end
      default: ;
    endcase
  end

  assign o_valid = valid_q;
  assign o_code  = code_q;
  assign o_pend  = pend_q;
  assign o_any   = |pend_q;

endmodule

// File: tb/tb_priority_enc_q_v.sv
// Scoreboard bench for priority_enc_q_v (N_IN=8, default fixed-priority build).
module tb_priority_enc_q_v;

  localparam int N = 8;

  logic         i_clk;
  logic         i_rst;
  logic [N-1:0] i_req;
  logic         i_ready;
  logic         o_valid;
  logic [2:0]   o_code;
  logic [N-1:0] o_pend;
  logic         o_any;

  typedef struct packed {
    logic         valid;
    logic [2:0]   code;
    logic [N-1:0] pend;
    logic         any;
  } exp_t;

  exp_t         sb_queue[$];
  int           assert_count;
  int           fail_count;
  logic [N-1:0] m_pend;
  logic         m_valid;
  logic [2:0]   m_code;

  priority_enc_q_v #(.N_IN(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_code  (o_code),
    .o_pend  (o_pend),
    .o_any   (o_any)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [2:0] highest(input logic [N-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare the DUT after the edge
  task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic ready);
    exp_t         e;
    logic [N-1:0] nxt;
    i_rst   = rst;
    i_req   = req;
    i_ready = ready;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_code  = 3'd0;
    end else begin
      nxt = m_pend;
      if (m_valid && ready) nxt[m_code] = 1'b0;
      nxt = nxt | req;
      if (!m_valid) begin
        if (m_pend != '0) begin
          m_valid = 1'b1;
          m_code  = highest(m_pend);
        end
      end else if (ready) begin
        if (nxt != '0) begin
          m_code = highest(nxt);
        end else begin
          m_valid = 1'b0;
          m_code  = 3'd0;
        end
      end
      m_pend = nxt;
    end
    e.valid = m_valid;
    e.code  = m_code;
    e.pend  = m_pend;
    e.any   = |m_pend;
    sb_queue.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb_queue.pop_front();
    checkOutput("sb_valid", 32'(o_valid), 32'(e.valid));
    checkOutput("sb_code",  32'(o_code),  32'(e.code));
    checkOutput("sb_pend",  32'(o_pend),  32'(e.pend));
    checkOutput("sb_any",   32'(o_any),   32'(e.any));
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    m_pend       = '0;
    m_valid      = 1'b0;
    m_code       = 3'd0;
    i_rst        = 1'b1;
    i_req        = '0;
    i_ready      = 1'b0;

    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("idle_valid", 32'(o_valid), 32'd0);
      checkOutput("idle_pend", 32'(o_pend), 32'h00);
    end

    // Two sources in one pulse, drained back-to-back
    applyStimulus(1'b0, 8'h24, 1'b1);
    checkOutput("t2_pend", 32'(o_pend), 32'h24);
    checkOutput("t2_valid_lat", 32'(o_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t2_code5", 32'(o_code), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t2_code2", 32'(o_code), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t2_done_valid", 32'(o_valid), 32'd0);
    checkOutput("t2_done_pend", 32'(o_pend), 32'h00);

    // Stalled consumer: no preemption by a later higher-priority request
    applyStimulus(1'b0, 8'h04, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h80, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t3_hold_code", 32'(o_code), 32'd2);
    checkOutput("t3_hold_pend", 32'(o_pend), 32'h84);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t3_code7", 32'(o_code), 32'd7);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Clear and re-request of the same bit in one cycle
    applyStimulus(1'b0, 8'h08, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t4_code3", 32'(o_code), 32'd3);
    applyStimulus(1'b0, 8'h08, 1'b1);
    checkOutput("t4_pend_bit3", 32'(o_pend[3]), 32'd1);
    checkOutput("t4_code3_again", 32'(o_code), 32'd3);
    checkOutput("t4_valid_again", 32'(o_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Reset while presenting discards everything, including the reset-cycle request
    applyStimulus(1'b0, 8'hFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("t5_valid", 32'(o_valid), 32'd0);
    checkOutput("t5_code", 32'(o_code), 32'd0);
    checkOutput("t5_pend", 32'(o_pend), 32'h00);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t5_after_pend", 32'(o_pend), 32'h00);

    // Saturated requests with an always-ready consumer
    applyStimulus(1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1);
      checkOutput("t6_code7", 32'(o_code), 32'd7);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    8'($urandom) & 8'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
